// File: rtl/uart_rx_pkg.sv
// Serial-link shared definitions: receiver state encoding, 8N1 frame constants
// and the three-sample majority vote.
package uart_rx_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    typedef enum logic [2:0] {
        RX_IDLE  = ST_IDLE,
        RX_START = ST_START,
        RX_DATA  = ST_DATA,
        RX_STOP  = ST_STOP,
        RX_BREAK = ST_BREAK
    } rx_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte hand-off from the receiver to its consumer: holding register, ack, error pulses.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ack;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ack
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ack
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pin plus a previous-value flop; flags a
// falling edge only once the synchronized line has been seen high after reset.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic line_o,
    output logic fall_o
);
    logic       s1_q, s2_q, s3_q;
    logic [1:0] settle_q, settle_d;
    logic       armed_q, armed_d;

    // s2 carries the real line only two edges after reset; until then it is the reset 1.
    always_comb begin
        settle_d = {settle_q[0], 1'b1};
        armed_d  = armed_q | (settle_q[1] & s2_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            s3_q     <= 1'b1;
            settle_q <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            s1_q     <= pin_i;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            settle_q <= settle_d;
            armed_q  <= armed_d;
        end
    end

    assign line_o = s2_q;
    assign fall_o = armed_q & s3_q & ~s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: mid-bit majority vote at OVERSAMPLE clocks per bit, frame FSM,
// and a one-entry holding register with valid/ack, framing and overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      pin_i,
    uart_rx_if.master rx
);
    localparam int H  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_SMP0 = CW'(H - 1);
    localparam logic [CW-1:0] CNT_SMP1 = CW'(H);
    localparam logic [CW-1:0] CNT_VOTE = CW'(H + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic line, fall;

    uart_rx_sync u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pin_i  (pin_i),
        .line_o (line),
        .fall_o (fall)
    );

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic vote_now, vote, done;

    assign vote_now = (cnt_q == CNT_VOTE);
    assign vote     = maj3(smp_q[1], smp_q[0], line);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        smp_d   = smp_q;
        done    = 1'b0;
        ferr_d  = 1'b0;

        // Tick counter runs free across START/DATA/STOP so votes stay OVERSAMPLE apart.
        if (state_q == RX_START || state_q == RX_DATA || state_q == RX_STOP) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
            if (cnt_q == CNT_SMP0) smp_d[1] = line;
            if (cnt_q == CNT_SMP1) smp_d[0] = line;
        end

        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = CW'(1);
                end
            end
            RX_START: begin
                if (vote_now) begin
                    if (vote == START_LEVEL) begin
                        state_d = RX_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (vote_now) begin
                    shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) state_d = RX_STOP;
                    else                   idx_d   = idx_q + IW'(1);
                end
            end
            RX_STOP: begin
                if (vote_now) begin
                    cnt_d = '0;
                    if (vote == STOP_LEVEL) begin
                        done    = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                cnt_d = '0;
                if (line) state_d = RX_IDLE;
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register: an ack coincident with completion lets the new byte replace the old one.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (done) begin
            if (!valid_q || rx.ack) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx.ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            smp_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx.data      = data_q;
    assign rx.valid     = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-by-bit on the pin, the
// expected output events are queued by time and a monitor matches what appears.
module tb_uart_rx;
    localparam int OS = 16;
    localparam int H  = OS / 2;

    typedef enum int {EV_LOAD, EV_OVR, EV_FERR, EV_CLR} ev_e;
    typedef struct {
        ev_e        k;
        logic [7:0] d;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pin = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t       exp_q[$];
    bit         full = 1'b0;
    logic [7:0] held = 8'h00;
    bit         pv = 1'b0;
    logic [7:0] pdata = 8'h00;

    uart_rx_if rif ();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .pin_i (pin),
        .rx    (rif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input ev_e k, input logic [7:0] d, input int t);
        exp_t e;
        int   i;
        e.k = k; e.d = d; e.t = t;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].t > t) i--;
        exp_q.insert(i, e);
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%02h want=%02h cyc=%0d", nm, act, want, cyc);
        end
    endtask

    task automatic got(input ev_e k, input logic [7:0] d);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got=%s data=%02h cyc=%0d", k.name(), d, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.k != k || e.t != cyc || ((k == EV_LOAD || k == EV_OVR) && e.d !== d)) begin
            errors++;
            $display("FAIL event got=%s/%02h@%0d want=%s/%02h@%0d",
                     k.name(), d, cyc, e.k.name(), e.d, e.t);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && cyc > exp_q[0].t) begin
            checks++;
            errors++;
            $display("FAIL missing_event want=%s/%02h@%0d cyc=%0d",
                     exp_q[0].k.name(), exp_q[0].d, exp_q[0].t, cyc);
            void'(exp_q.pop_front());
        end
        if (pv && rif.valid !== 1'b1) got(EV_CLR, rif.data);
        if (rif.valid === 1'b1 && (!pv || rif.data !== pdata)) got(EV_LOAD, rif.data);
        if (rif.overrun === 1'b1) got(EV_OVR, rif.data);
        if (rif.frame_err === 1'b1) got(EV_FERR, rif.data);
        pv    <= (rif.valid === 1'b1);
        pdata <= rif.data;
    end

    // One frame, one pin level per clock. spike: cycle index to invert; rst_at: cycle to pulse reset.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ack_done,
                              input int spike, input int extra_low, input int rst_at);
        logic [9:0] bits;
        int         e, t;
        logic       lvl;
        bits = {stop_ok, b, 1'b0};
        @(negedge clk);
        e = cyc + 1;
        t = e + 1 + 9 * OS + H + 2;
        if (rst_at < 0) begin
            if (!stop_ok)      push(EV_FERR, held, t);
            else if (!full)    begin push(EV_LOAD, b, t); full = 1'b1; held = b; end
            else if (ack_done) begin push(EV_LOAD, b, t); held = b; end
            else               push(EV_OVR, held, t);
        end
        for (int j = 0; j < 10 * OS; j++) begin
            if (j > 0) @(negedge clk);
            if (rst_at >= 0 && j == rst_at + 1) begin
                check("rst_valid", {7'd0, rif.valid}, 8'h00);
                check("rst_data", rif.data, 8'h00);
                check("rst_frame_err", {7'd0, rif.frame_err}, 8'h00);
                check("rst_overrun", {7'd0, rif.overrun}, 8'h00);
            end
            lvl = bits[j / OS];
            if (j == spike) lvl = ~lvl;
            pin     = lvl;
            rif.ack = ack_done && (cyc == t - 1);
            rst     = (rst_at >= 0 && j == rst_at);
            if (rst && full) begin
                push(EV_CLR, held, cyc + 1);
                full = 1'b0;
            end
        end
        if (!stop_ok) begin
            repeat (extra_low) @(negedge clk);
            @(negedge clk);
            pin = 1'b1;
            repeat (2 * OS) @(negedge clk);
        end
        rif.ack = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        if (full) begin
            push(EV_CLR, held, cyc + 1);
            full = 1'b0;
        end
        rif.ack = 1'b1;
        @(negedge clk);
        rif.ack = 1'b0;
    endtask

    task automatic glitch();
        repeat (5) begin @(negedge clk); pin = 1'b0; end
        repeat (7) begin @(negedge clk); pin = 1'b1; end
    endtask

    initial begin
        logic [7:0] b;
        bit         bad, ad;
        int         sp;
        rif.ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", {7'd0, rif.valid}, 8'h00);
        check("reset_data", rif.data, 8'h00);
        check("reset_frame_err", {7'd0, rif.frame_err}, 8'h00);
        check("reset_overrun", {7'd0, rif.overrun}, 8'h00);
        rst = 1'b0;
        repeat (2 * OS) @(negedge clk);

        send_frame(8'hA5, 1, 0, -1, 0, -1);
        do_ack();
        do_ack();

        send_frame(8'h01, 1, 0, -1, 0, -1);
        send_frame(8'h80, 1, 0, -1, 0, -1);
        do_ack();

        send_frame(8'h3C, 1, 0, -1, 0, -1);
        send_frame(8'hC3, 1, 1, -1, 0, -1);
        do_ack();

        glitch();
        send_frame(8'h5A, 1, 0, -1, 0, -1);
        do_ack();
        send_frame(8'h6D, 1, 0, 3 * OS + H, 0, -1);
        do_ack();

        send_frame(8'h55, 0, 0, -1, 0, -1);
        send_frame(8'h00, 0, 0, -1, 30 * OS, -1);
        send_frame(8'h7E, 1, 0, -1, 0, -1);

        send_frame(8'h0F, 1, 0, -1, 0, 5 * OS + 3);
        repeat (2 * OS) @(negedge clk);
        send_frame(8'h99, 1, 0, -1, 0, -1);
        do_ack();

        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 9) == 0);
            ad  = !bad && full && (b != held) && ($urandom_range(0, 3) == 0);
            sp  = ($urandom_range(0, 1) == 1) ? ($urandom_range(1, 8) * OS + H - 1 + $urandom_range(0, 2)) : -1;
            if (!ad && $urandom_range(0, 1) == 1) do_ack();
            send_frame(b, !bad, ad, sp, bad ? OS * $urandom_range(0, 3) : 0, -1);
            repeat ($urandom_range(0, 2) * OS) @(negedge clk);
        end

        repeat (4 * OS) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(600000);
        $display("FAIL watchdog got=timeout want=finish cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
